// File: rtl/leaves_pkg.sv
// Shared definitions for the leaves loader.
//   - Default parameter values used by leaves_loader and leaf_bank_counter.
//   - Loader FSM state encoding.
package leaves_pkg;

    localparam int DEF_DATA_WIDTH = 11;
    localparam int DEF_IDX_WIDTH  = 9;
    localparam int DEF_LEAF_SIZE  = 8;
    localparam int DEF_PATCH_SIZE = 5;
    localparam int DEF_NUM_LEAVES = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/leaf_bank_counter.sv
// Wrap counter producing the bank and leaf index of the next patch.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   clear      : restart at bank 0, leaf 0 (has priority over inc)
//   inc        : advance by one patch
//   bank       : bank index, wraps LEAF_SIZE-1 -> 0
//   leaf       : leaf index, advances in the same cycle the bank wraps
//   last       : current position is the final patch of the load
module leaf_bank_counter
    import leaves_pkg::*;
#(
    parameter int LEAF_SIZE  = DEF_LEAF_SIZE,
    parameter int NUM_LEAVES = DEF_NUM_LEAVES,
    parameter int BANK_W     = (LEAF_SIZE > 1) ? $clog2(LEAF_SIZE) : 1,
    parameter int LEAF_W     = (NUM_LEAVES > 1) ? $clog2(NUM_LEAVES) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              inc,
    output logic [BANK_W-1:0] bank,
    output logic [LEAF_W-1:0] leaf,
    output logic              last
);

    localparam logic [BANK_W-1:0] BANK_MAX = BANK_W'(LEAF_SIZE - 1);
    localparam logic [LEAF_W-1:0] LEAF_MAX = LEAF_W'(NUM_LEAVES - 1);

    logic [BANK_W-1:0] bank_reg;
    logic [LEAF_W-1:0] leaf_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bank_reg <= '0;
            leaf_reg <= '0;
        end else if (clear) begin
            bank_reg <= '0;
            leaf_reg <= '0;
        end else if (inc) begin
            if (bank_reg == BANK_MAX) begin
                bank_reg <= '0;
                leaf_reg <= (leaf_reg == LEAF_MAX) ? '0 : leaf_reg + 1'b1;
            end else begin
                bank_reg <= bank_reg + 1'b1;
            end
        end
    end

    assign bank = bank_reg;
    assign leaf = leaf_reg;
    assign last = (bank_reg == BANK_MAX) && (leaf_reg == LEAF_MAX);

endmodule

// File: rtl/leaves_loader.sv
// Streams patches into a banked leaves memory: patch k goes to bank
// k mod LEAF_SIZE at leaf address k / LEAF_SIZE. The memory write port
// outputs are registered, so a write appears one cycle after acceptance.
// Ports:
//   clk, rst_n         : clock, asynchronous active-low reset
//   start              : begins a load (ignored while loading)
//   in_valid/in_ready  : patch handshake; in_ready is high only in LOAD
//   in_data, in_idx    : patch elements (element 0 in LSBs) and index
//   busy, done         : load in progress / load complete (level)
//   wr_count           : patches accepted since the last start
//   csb0, web0         : per-bank active-low select and write enable
//   addr0, wleaf0      : leaf address and write word {in_idx, in_data}
module leaves_loader
    import leaves_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int IDX_WIDTH  = DEF_IDX_WIDTH,
    parameter int LEAF_SIZE  = DEF_LEAF_SIZE,
    parameter int PATCH_SIZE = DEF_PATCH_SIZE,
    parameter int NUM_LEAVES = DEF_NUM_LEAVES,
    parameter int LEAF_ADDRW = $clog2(NUM_LEAVES)
) (
    input  logic                                      clk,
    input  logic                                      rst_n,
    input  logic                                      start,
    input  logic                                      in_valid,
    output logic                                      in_ready,
    input  logic [PATCH_SIZE*DATA_WIDTH-1:0]          in_data,
    input  logic [IDX_WIDTH-1:0]                      in_idx,
    output logic                                      busy,
    output logic                                      done,
    output logic [$clog2(NUM_LEAVES*LEAF_SIZE+1)-1:0] wr_count,
    output logic [LEAF_SIZE-1:0]                      csb0,
    output logic [LEAF_SIZE-1:0]                      web0,
    output logic [LEAF_ADDRW-1:0]                     addr0,
    output logic [PATCH_SIZE*DATA_WIDTH+IDX_WIDTH-1:0] wleaf0
);

    localparam int WORD_W = PATCH_SIZE * DATA_WIDTH + IDX_WIDTH;
    localparam int CNT_W  = $clog2(NUM_LEAVES * LEAF_SIZE + 1);
    localparam int BANK_W = (LEAF_SIZE > 1) ? $clog2(LEAF_SIZE) : 1;

    state_t                  state_reg;
    logic [CNT_W-1:0]        wr_count_reg;
    logic [LEAF_SIZE-1:0]    csb_reg;
    logic [LEAF_SIZE-1:0]    web_reg;
    logic [LEAF_ADDRW-1:0]   addr_reg;
    logic [WORD_W-1:0]       wleaf_reg;

    logic                    accept;
    logic                    launch;
    logic [BANK_W-1:0]       bank;
    logic [LEAF_ADDRW-1:0]   leaf;
    logic                    last_patch;
    logic [LEAF_SIZE-1:0]    bank_hit;

    // Handshake depends only on registered state, so in_valid reaches the
    // strobes solely through the write-port registers.
    assign accept = in_valid && (state_reg == LOAD);
    assign launch = start && (state_reg != LOAD);

    leaf_bank_counter #(
        .LEAF_SIZE  (LEAF_SIZE),
        .NUM_LEAVES (NUM_LEAVES),
        .BANK_W     (BANK_W),
        .LEAF_W     (LEAF_ADDRW)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (launch),
        .inc   (accept),
        .bank  (bank),
        .leaf  (leaf),
        .last  (last_patch)
    );

    for (genvar gi = 0; gi < LEAF_SIZE; gi++) begin : g_bank
        assign bank_hit[gi] = accept && (bank == BANK_W'(gi));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= IDLE;
            wr_count_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: if (start) state_reg <= LOAD;
                LOAD: if (accept && last_patch) state_reg <= DONE;
                DONE: if (start) state_reg <= LOAD;
                default: state_reg <= IDLE;
            endcase
            if (launch) begin
                wr_count_reg <= '0;
            end else if (accept) begin
                wr_count_reg <= wr_count_reg + 1'b1;
            end
        end
    end

    // Write port: strobes fall to all-ones in any cycle without a write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            csb_reg   <= '1;
            web_reg   <= '1;
            addr_reg  <= '0;
            wleaf_reg <= '0;
        end else begin
            csb_reg <= ~bank_hit;
            web_reg <= ~bank_hit;
            if (accept) begin
                addr_reg  <= leaf;
                wleaf_reg <= {in_idx, in_data};
            end
        end
    end

    assign in_ready = (state_reg == LOAD);
    assign busy     = (state_reg == LOAD);
    assign done     = (state_reg == DONE);
    assign wr_count = wr_count_reg;
    assign csb0     = csb_reg;
    assign web0     = web_reg;
    assign addr0    = addr_reg;
    assign wleaf0   = wleaf_reg;

endmodule

// File: tb/tb_leaves_loader.sv
module tb_leaves_loader;
    import leaves_pkg::*;

    localparam int DW = 11;
    localparam int IW = 9;
    localparam int LS = 8;
    localparam int PS = 5;
    localparam int NL = 64;
    localparam int AW = 6;
    localparam int NP = NL * LS;
    localparam int WW = PS * DW + IW;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic          in_valid = 1'b0;
    logic [PS*DW-1:0] in_data = '0;
    logic [IW-1:0] in_idx = '0;
    logic          in_ready, busy, done;
    logic [9:0]    wr_count;
    logic [LS-1:0] csb0, web0;
    logic [AW-1:0] addr0;
    logic [WW-1:0] wleaf0;

    leaves_loader dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .in_idx   (in_idx),
        .busy     (busy),
        .done     (done),
        .wr_count (wr_count),
        .csb0     (csb0),
        .web0     (web0),
        .addr0    (addr0),
        .wleaf0   (wleaf0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Leaves memory attached to the write port.
    logic [WW-1:0] mem [LS][NL];
    always @(posedge clk) begin
        cyc <= cyc + 1;
        for (int b = 0; b < LS; b++)
            if (!csb0[b] && !web0[b]) mem[b][addr0] <= wleaf0;
    end

    // Write log, sampled mid-cycle.
    int            log_bank[$];
    int            log_addr[$];
    int            log_cyc[$];
    logic [WW-1:0] log_word[$];
    int            mon_b;
    int            mon_z;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && csb0 !== 8'hFF) begin
            mon_b = -1;
            mon_z = 0;
            for (int i = 0; i < LS; i++)
                if (!csb0[i]) begin
                    mon_z++;
                    mon_b = i;
                end
            chk("strobe_onehot", 64'(mon_z), 64'd1);
            chk("web_eq_csb", 64'(web0), 64'(csb0));
            log_bank.push_back(mon_b);
            log_addr.push_back(int'(addr0));
            log_cyc.push_back(cyc);
            log_word.push_back(wleaf0);
        end
    end

    function automatic logic [PS*DW-1:0] patch_data(input int k, input int seed);
        logic [PS*DW-1:0] d;
        for (int e = 0; e < PS; e++) d[e*DW +: DW] = DW'(k * 13 + e * 101 + seed * 7);
        return d;
    endfunction

    function automatic logic [WW-1:0] exp_word(input int k, input int seed);
        return {IW'(k), patch_data(k, seed)};
    endfunction

    function automatic logic [7:0] strobe_of(input int k);
        logic [7:0] one;
        one = 8'h01;
        return ~(one << (k % LS));
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int k, input int seed, input logic v);
        in_valid = v;
        in_idx   = IW'(k);
        in_data  = patch_data(k, seed);
    endtask

    task automatic clear_log();
        log_bank.delete();
        log_addr.delete();
        log_cyc.delete();
        log_word.delete();
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        start = 1'b0;
        in_valid = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        step();
        clear_log();
    endtask

    task automatic do_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    // Full back-to-back load of all patches with the given data seed.
    task automatic full_load(input int seed, output int not_ready);
        not_ready = 0;
        for (int k = 0; k < NP; k++) begin
            drive(k, seed, 1'b1);
            if (in_ready !== 1'b1) not_ready++;
            step();
        end
        in_valid = 1'b0;
    endtask

    typedef struct {
        logic       start;
        logic       valid;
        int         idx;
        logic       exp_ready;
        logic       exp_busy;
        logic       exp_done;
        logic [7:0] exp_csb;
        int         exp_wrc;
    } vec_t;

    typedef struct {
        int k;
        int bank;
        int addr;
    } probe_t;

    vec_t   vecs[8];
    probe_t probes[6];

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int errs, errs2, nr, k, guard, nlog;
        logic v;

        vecs[0] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'hFF, 0};
        vecs[1] = '{1'b0, 1'b1, 0, 1'b0, 1'b0, 1'b0, 8'hFF, 0};
        vecs[2] = '{1'b1, 1'b0, 0, 1'b1, 1'b1, 1'b0, 8'hFF, 0};
        vecs[3] = '{1'b0, 1'b1, 0, 1'b1, 1'b1, 1'b0, 8'hFE, 1};
        vecs[4] = '{1'b0, 1'b0, 1, 1'b1, 1'b1, 1'b0, 8'hFF, 1};
        vecs[5] = '{1'b0, 1'b1, 1, 1'b1, 1'b1, 1'b0, 8'hFD, 2};
        vecs[6] = '{1'b1, 1'b1, 2, 1'b1, 1'b1, 1'b0, 8'hFB, 3};
        vecs[7] = '{1'b0, 1'b1, 3, 1'b1, 1'b1, 1'b0, 8'hF7, 4};

        probes[0] = '{0, 0, 0};
        probes[1] = '{1, 1, 0};
        probes[2] = '{8, 0, 1};
        probes[3] = '{9, 1, 1};
        probes[4] = '{100, 4, 12};
        probes[5] = '{511, 7, 63};

        // Reset state while rst_n is held low.
        in_valid = 1'b1;
        step();
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_wr_count", 64'(wr_count), 64'd0);
        chk("rst_csb0", 64'(csb0), 64'hFF);
        chk("rst_web0", 64'(web0), 64'hFF);
        chk("rst_addr0", 64'(addr0), 64'd0);
        chk("rst_wleaf0", wleaf0, 64'd0);
        in_valid = 1'b0;
        rst_n = 1'b1;
        step();

        // Table: idle in_valid ignored, start, sparse writes, start ignored in LOAD.
        for (int i = 0; i < 8; i++) begin
            start = vecs[i].start;
            drive(vecs[i].idx, 0, vecs[i].valid);
            step();
            $display("vec %0d start=%0d valid=%0d idx=%0d -> ready=%0d busy=%0d csb0=%h wr_count=%0d",
                     i, start, in_valid, vecs[i].idx, in_ready, busy, csb0, wr_count);
            chk($sformatf("vec%0d_ready", i), 64'(in_ready), 64'(vecs[i].exp_ready));
            chk($sformatf("vec%0d_busy", i), 64'(busy), 64'(vecs[i].exp_busy));
            chk($sformatf("vec%0d_done", i), 64'(done), 64'(vecs[i].exp_done));
            chk($sformatf("vec%0d_csb0", i), 64'(csb0), 64'(vecs[i].exp_csb));
            chk($sformatf("vec%0d_wr_count", i), 64'(wr_count), 64'(vecs[i].exp_wrc));
            if (vecs[i].exp_csb != 8'hFF)
                chk($sformatf("vec%0d_idx", i), 64'(wleaf0[WW-1 -: IW]), 64'(vecs[i].idx));
        end
        start = 1'b0;

        // Full back-to-back load.
        do_reset();
        do_start();
        chk("a_busy_after_start", 64'(busy), 64'd1);
        full_load(1, nr);
        chk("a_ready_throughout", 64'(nr), 64'd0);
        chk("a_done", 64'(done), 64'd1);
        chk("a_ready_low", 64'(in_ready), 64'd0);
        chk("a_busy_low", 64'(busy), 64'd0);
        chk("a_wr_count", 64'(wr_count), 64'(NP));
        chk("a_last_csb0", 64'(csb0), 64'h7F);
        chk("a_last_addr0", 64'(addr0), 64'd63);
        step();
        chk("a_idle_csb0", 64'(csb0), 64'hFF);
        chk("a_done_hold", 64'(done), 64'd1);
        in_valid = 1'b1;
        step();
        step();
        in_valid = 1'b0;
        chk("a_done_valid_ignored", 64'(log_bank.size()), 64'(NP));
        chk("a_done_csb0", 64'(csb0), 64'hFF);
        errs = 0;
        for (int i = 0; i < log_cyc.size(); i++)
            if (log_cyc[i] != log_cyc[0] + i || log_bank[i] != i % LS || log_addr[i] != i / LS) errs++;
        chk("a_consecutive_sequence", 64'(errs), 64'd0);
        for (int i = 0; i < 6; i++) begin
            k = probes[i].k;
            $display("probe k=%0d bank=%0d addr=%0d", k,
                     (k < log_bank.size()) ? log_bank[k] : -1, (k < log_addr.size()) ? log_addr[k] : -1);
            if (k < log_bank.size()) begin
                chk($sformatf("probe%0d_bank", k), 64'(log_bank[k]), 64'(probes[i].bank));
                chk($sformatf("probe%0d_addr", k), 64'(log_addr[k]), 64'(probes[i].addr));
                chk($sformatf("probe%0d_word", k), log_word[k], exp_word(k, 1));
            end else begin
                chk($sformatf("probe%0d_logged", k), 64'(log_bank.size()), 64'(k + 1));
            end
            chk($sformatf("probe%0d_mem", k), mem[probes[i].bank][probes[i].addr], exp_word(k, 1));
        end

        // Second start after done: restarts from bank 0, addr 0.
        clear_log();
        do_start();
        chk("e_done_cleared", 64'(done), 64'd0);
        chk("e_busy", 64'(busy), 64'd1);
        chk("e_wr_count_cleared", 64'(wr_count), 64'd0);
        full_load(2, nr);
        step();
        step();
        chk("e_done", 64'(done), 64'd1);
        chk("e_log_size", 64'(log_bank.size()), 64'(NP));
        if (log_bank.size() > 0) begin
            chk("e_first_bank", 64'(log_bank[0]), 64'd0);
            chk("e_first_addr", 64'(log_addr[0]), 64'd0);
        end
        errs = 0;
        errs2 = 0;
        for (int i = 0; i < NP; i++) begin
            if (mem[i % LS][i / LS] !== exp_word(i, 2)) errs++;
            if (mem[i % LS][i / LS][WW-1 -: IW] !== IW'(i)) errs2++;
        end
        chk("e_mem_readback", 64'(errs), 64'd0);
        chk("e_mem_idx_field", 64'(errs2), 64'd0);

        // Random 50% in_valid.
        do_reset();
        do_start();
        k = 0;
        guard = 0;
        errs = 0;
        while (k < NP && guard < 5000) begin
            v = 1'($urandom_range(0, 1));
            drive(k, 3, v);
            step();
            if (csb0 !== (v ? strobe_of(k) : 8'hFF)) errs++;
            if (v) k++;
            guard++;
        end
        in_valid = 1'b0;
        chk("b_all_accepted", 64'(k), 64'(NP));
        step();
        chk("b_strobe_per_cycle", 64'(errs), 64'd0);
        chk("b_log_size", 64'(log_bank.size()), 64'(NP));
        errs = 0;
        for (int i = 0; i < log_bank.size(); i++)
            if (log_bank[i] != i % LS || log_addr[i] != i / LS || log_word[i] !== exp_word(i, 3)) errs++;
        chk("b_sequence", 64'(errs), 64'd0);
        chk("b_done", 64'(done), 64'd1);

        // start pulsed during LOAD at patch 100.
        do_reset();
        do_start();
        for (int i = 0; i < 100; i++) begin
            drive(i, 4, 1'b1);
            step();
        end
        drive(100, 4, 1'b1);
        start = 1'b1;
        step();
        start = 1'b0;
        chk("c_wr_count_101", 64'(wr_count), 64'd101);
        chk("c_busy", 64'(busy), 64'd1);
        chk("c_csb0_100", 64'(csb0), 64'(strobe_of(100)));
        drive(101, 4, 1'b1);
        step();
        chk("c_wr_count_102", 64'(wr_count), 64'd102);
        in_valid = 1'b0;
        step();

        // Reset mid-load after patch 37.
        do_reset();
        do_start();
        for (int i = 0; i <= 37; i++) begin
            drive(i, 5, 1'b1);
            step();
        end
        chk("d_strobe_37", 64'(csb0), 64'(strobe_of(37)));
        rst_n = 1'b0;
        #1;
        chk("d_csb0_abort", 64'(csb0), 64'hFF);
        chk("d_web0_abort", 64'(web0), 64'hFF);
        chk("d_busy_abort", 64'(busy), 64'd0);
        chk("d_wr_count_abort", 64'(wr_count), 64'd0);
        chk("d_ready_abort", 64'(in_ready), 64'd0);
        step();
        rst_n = 1'b1;
        nlog = log_bank.size();
        errs = 0;
        for (int i = 0; i < 4; i++) begin
            drive(38 + i, 5, 1'b1);
            step();
            if (csb0 !== 8'hFF) errs++;
        end
        in_valid = 1'b0;
        chk("d_no_resume_strobe", 64'(errs), 64'd0);
        chk("d_no_resume_log", 64'(log_bank.size()), 64'(nlog));
        chk("d_idle_busy", 64'(busy), 64'd0);
        chk("d_idle_wr_count", 64'(wr_count), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
